dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one CPU load/store at a time, waits a fixed
// number of cycles, performs the access on the edge entering RESP and holds
// the registered response until the CPU consumes it.
module dmem_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH_WORDS   = 1024,
    parameter int WAIT_CYCLES   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t                     state;
    state_t                     nextState;
    logic [3:0]                 waitCnt;
    logic                       latWrite;
    logic [ADDRESS_WIDTH-1:0]   latAddr;
    logic [1:0]                 latSize;
    logic                       latUns;
    logic [31:0]                latWdata;
    logic [31:0]                mem [DEPTH_WORDS];
    logic                       accept;
    logic                       enterResp;
    logic                       opWrite;
    logic [ADDRESS_WIDTH-1:0]   opAddr;
    logic [1:0]                 opSize;
    logic                       opUns;
    logic [31:0]                opWdata;
    logic                       opErr;
    logic [IDX_W-1:0]           wordIdx;
    logic [3:0]                 opMask;
    logic [31:0]                opLaneData;

    // Misaligned, reserved-size and out-of-range accesses are rejected.
    function automatic logic accessError(input logic [ADDRESS_WIDTH-1:0] addr,
                                         input logic [1:0] size);
        logic err;
        err = 1'b0;
        case (size)
            2'b01:   err = addr[0];
            2'b10:   err = |addr[1:0];
            2'b11:   err = 1'b1;
            default: err = 1'b0;
        endcase
        if ({2'b00, addr[ADDRESS_WIDTH-1:2]} >= ADDRESS_WIDTH'(DEPTH_WORDS))
            err = 1'b1;
        return err;
    endfunction

    // Little-endian byte-lane enables for a store.
    function automatic logic [3:0] laneMask(input logic [1:0] lane, input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data onto every lane it may land in.
    function automatic logic [31:0] laneData(input logic [31:0] wdata, input logic [1:0] size);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Right-align the addressed lanes and extend to 32 bits.
    function automatic logic [31:0] extendLoad(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   return uns ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            2'b10:   return word;
            default: return 32'h0;
        endcase
    endfunction

    assign accept    = req_valid && (state == IDLE);
    assign enterResp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (waitCnt == 4'd1));

    // With zero wait states the access happens on the accept edge itself,
    // before the latches are loaded, so the live request is used there.
    assign opWrite    = (state == IDLE) ? req_write    : latWrite;
    assign opAddr     = (state == IDLE) ? req_addr     : latAddr;
    assign opSize     = (state == IDLE) ? req_size     : latSize;
    assign opUns      = (state == IDLE) ? req_unsigned : latUns;
    assign opWdata    = (state == IDLE) ? req_wdata    : latWdata;
    assign opErr      = accessError(opAddr, opSize);
    assign wordIdx    = opAddr[IDX_W+1:2];
    assign opMask     = laneMask(opAddr[1:0], opSize);
    assign opLaneData = laneData(opWdata, opSize);

    // State register and wait-state counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
        end else begin
            state <= nextState;
            if (accept)
                waitCnt <= 4'(WAIT_CYCLES);
            else if (state == WAIT)
                waitCnt <= waitCnt - 4'd1;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (req_valid) nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (waitCnt == 4'd1) nextState = RESP;
            RESP:    if (rsp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Handshake outputs depend on state only.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Capture the request on the accept edge; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            latWrite <= req_write;
            latAddr  <= req_addr;
            latSize  <= req_size;
            latUns   <= req_unsigned;
            latWdata <= req_wdata;
        end
    end

    // Register the response on the edge entering RESP and hold it there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (enterResp) begin
            rsp_err   <= opErr;
            rsp_rdata <= (opWrite || opErr) ? 32'h0
                                            : extendLoad(mem[wordIdx], opAddr[1:0], opSize, opUns);
        end
    end

    // Commit stores on the edge entering RESP; storage itself is never reset.
    always_ff @(posedge clk) begin
        if (enterResp && opWrite && !opErr) begin
            for (int l = 0; l < 4; l++) begin
                if (opMask[l])
                    mem[wordIdx][8*l +: 8] <= opLaneData[8*l +: 8];
            end
        end
    end
endmodule
